monolith_axis_chunk_tx: RTL

Chunk-to-stream egress stage of the Monolith streaming accelerator. Accepts complete result chunks (CHUNK_SIZE words in parallel) from the permutation core over a valid/ready handshake. Buffers up to CHUNK_COUNT chunks and serialises them word by word onto an AXI4-Stream master toward the DMA. It is the output-side counterpart of the chunked AXIS ingress buffer.

---
 rtl/monolith_axis_pkg.sv | 22 ++
 rtl/monolith_chunk_buffer.sv | 51 +++++
 rtl/monolith_axis_chunk_tx.sv | 79 +++++++
 3 files changed

// File: rtl/monolith_axis_pkg.sv
// Shared types and width helpers for the Monolith chunked AXIS ingress/egress stages.
package monolith_axis_pkg;

  localparam int CHUNK_SIZE_DEF    = 16;
  localparam int CHUNK_COUNT_DEF   = 2;
  localparam int PACKET_CHUNKS_DEF = 1;
  localparam int TDATA_W_DEF       = 32;

  // Counter width that stays >= 1 bit when the range collapses to a single value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PTR_W = $clog2(CHUNK_COUNT_DEF) + 1;
  localparam int IDX_W = cnt_w(CHUNK_SIZE_DEF);
  localparam int PKT_W = cnt_w(PACKET_CHUNKS_DEF);

  typedef logic [CHUNK_SIZE_DEF-1:0][TDATA_W_DEF-1:0] chunk_t;

  typedef enum logic {TX_IDLE, TX_STREAM} tx_state_e;

endpackage

// File: rtl/monolith_chunk_buffer.sv
// Chunk-slot ring buffer: storage, wrap-bit pointers and occupancy flags.
module monolith_chunk_buffer
  import monolith_axis_pkg::*;
#(
  parameter int CHUNK_SIZE  = CHUNK_SIZE_DEF,
  parameter int CHUNK_COUNT = CHUNK_COUNT_DEF,
  parameter int DATA_W      = TDATA_W_DEF,
  localparam int IW = cnt_w(CHUNK_SIZE),
  localparam int SW = $clog2(CHUNK_COUNT),
  localparam int PW = SW + 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              wr_en_i,
  input  logic [CHUNK_SIZE-1:0][DATA_W-1:0] wr_chunk_i,
  input  logic                              rd_adv_i,
  input  logic [IW-1:0]                     rd_idx_i,
  output logic [DATA_W-1:0]                 rd_word_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [PW-1:0]                     pending_o
);

  logic [CHUNK_SIZE-1:0][DATA_W-1:0] mem_q [CHUNK_COUNT];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          wr_fire, rd_fire;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[SW-1:0] == rd_ptr_q[SW-1:0]) && (wr_ptr_q[SW] != rd_ptr_q[SW]);
  assign pending_o = wr_ptr_q - rd_ptr_q;
  assign rd_word_o = mem_q[rd_ptr_q[SW-1:0]][rd_idx_i];

  // Full is sampled before this cycle's drain, so a slot freed now is not reusable until next cycle.
  assign wr_fire = wr_en_i && !full_o;
  assign rd_fire = rd_adv_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int s = 0; s < CHUNK_COUNT; s++) mem_q[s] <= '0;
    end else begin
      if (wr_fire) begin
        mem_q[wr_ptr_q[SW-1:0]] <= wr_chunk_i;
        wr_ptr_q                <= wr_ptr_q + PW'(1);
      end
      if (rd_fire) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

endmodule

// File: rtl/monolith_axis_chunk_tx.sv
// Egress stage: buffers whole chunks and serialises them word by word onto an AXIS master.
module monolith_axis_chunk_tx
  import monolith_axis_pkg::*;
#(
  parameter int CHUNK_SIZE           = CHUNK_SIZE_DEF,
  parameter int CHUNK_COUNT          = CHUNK_COUNT_DEF,
  parameter int PACKET_CHUNKS        = PACKET_CHUNKS_DEF,
  parameter int C_M_AXIS_TDATA_WIDTH = TDATA_W_DEF,
  localparam int IW = cnt_w(CHUNK_SIZE),
  localparam int PW = $clog2(CHUNK_COUNT) + 1,
  localparam int KW = cnt_w(PACKET_CHUNKS)
) (
  input  logic                                            M_AXIS_ACLK,
  input  logic                                            M_AXIS_ARESETN,
  input  logic [CHUNK_SIZE-1:0][C_M_AXIS_TDATA_WIDTH-1:0] chunk_in,
  input  logic                                            chunk_valid,
  output logic                                            chunk_ready,
  output logic [PW-1:0]                                   chunks_pending,
  output logic                                            M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]                 M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]               M_AXIS_TSTRB,
  output logic                                            M_AXIS_TLAST,
  input  logic                                            M_AXIS_TREADY
);

  logic [IW-1:0] word_idx_q, word_idx_d;
  logic [KW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          full, empty, xfer, last_word, pkt_last, chunk_done;
  tx_state_e     state;

  monolith_chunk_buffer #(
    .CHUNK_SIZE  (CHUNK_SIZE),
    .CHUNK_COUNT (CHUNK_COUNT),
    .DATA_W      (C_M_AXIS_TDATA_WIDTH)
  ) u_buf (
    .clk_i      (M_AXIS_ACLK),
    .rst_ni     (M_AXIS_ARESETN),
    .wr_en_i    (chunk_valid),
    .wr_chunk_i (chunk_in),
    .rd_adv_i   (chunk_done),
    .rd_idx_i   (word_idx_q),
    .rd_word_o  (M_AXIS_TDATA),
    .full_o     (full),
    .empty_o    (empty),
    .pending_o  (chunks_pending)
  );

  // Streaming state is a pure function of occupancy; no separate state register.
  assign state      = empty ? TX_IDLE : TX_STREAM;
  assign xfer       = (state == TX_STREAM) && M_AXIS_TREADY;
  assign last_word  = (word_idx_q == IW'(CHUNK_SIZE - 1));
  assign pkt_last   = (pkt_cnt_q == KW'(PACKET_CHUNKS - 1));
  assign chunk_done = xfer && last_word;

  always_comb begin
    word_idx_d = word_idx_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (xfer) begin
      word_idx_d = last_word ? '0 : word_idx_q + IW'(1);
      if (last_word) pkt_cnt_d = pkt_last ? '0 : pkt_cnt_q + KW'(1);
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      word_idx_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      word_idx_q <= word_idx_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign M_AXIS_TVALID = (state == TX_STREAM);
  assign M_AXIS_TLAST  = M_AXIS_TVALID && last_word && pkt_last;
  assign M_AXIS_TSTRB  = '1;
  assign chunk_ready   = !full;

endmodule
